bcd_field_writer: RTL
=====================

# bcd_field_writer

Parametrised numeric-field writer for the UI state RAM. It accepts a binary value and runs a sequential double-dabble conversion. It then emits one write per decimal digit, plus a suffix cell, into a fixed field of the state RAM write port. It generalises the per-result write sequence of the UI state transfer path, so each numeric field on screen becomes one instance.

## Interface
- WIDTH, 28: binary input width.
- DIGITS, ceil(log10(2)*WIDTH): number of decimal cells. Elaboration error if smaller than the default.
- FIELD_BASE, 10'h000: state RAM address of the most significant digit cell.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request pulse. Accepted only when o_busy is 0.
- i_value  in  WIDTH  value to display. Sampled on the acceptance cycle only.
- i_attr  in  8  colour/attribute byte, written to wdata[7:0] of every cell. Sampled on the acceptance cycle.
- o_busy  out  1  high from the cycle after acceptance until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_we  out  1  state RAM write enable.
- o_waddr  out  10  state RAM write address.
- o_wdata  out  16  {char[7:0], attr[7:0]}.

## Operation
- States:
  - IDLE: i_start moves to CONVERT, loads the shift register, latches attr, and sets untracked = &i_value.
  - CONVERT: WIDTH add-3/shift steps, then EMIT.
  - EMIT: DIGITS+1 writes, then DONE.
  - DONE: o_done=1, then IDLE.
- EMIT order:
  - Index k = 0..DIGITS-1 writes digit DIGITS-1-k (MS first) to FIELD_BASE+k.
  - Index DIGITS writes ui::CHAR_SUFFIX (8'hBB) to FIELD_BASE+DIGITS.
- Digit character:
  - untracked: every digit cell is ui::CHAR_BLANK (8'hF6).
  - otherwise: ui::CHAR_ZERO + bcd digit.
  - The suffix is always written.
- Address arithmetic is 10-bit modulo 1024. The field wraps past 10'h3FF to 10'h000.
- i_start while busy or in DONE is ignored, with no queuing. i_value changes after acceptance have no effect.
- The shift counter is $clog2(WIDTH+1) bits wide. The input is not padded.
- Reset (any time, including mid-EMIT):
  - state goes to IDLE.
  - o_we, o_busy, o_done, o_waddr and o_wdata go to 0.
  - The shift register is cleared.
  - No partial-write completion or done pulse follows.

## Timing
- Cycle 0 is i_start high while IDLE.
- Cycles 1..WIDTH: conversion. o_busy=1, o_we=0.
- Cycles WIDTH+1..WIDTH+DIGITS+1: o_we=1, one cell per cycle. Outputs are registered.
- Cycle WIDTH+DIGITS+2: o_done=1, o_busy=0, o_we=0.
- The earliest next acceptance is the cycle after o_done.
- Latency is fixed and independent of value.

## Configuration
- BCD_FIELD_WRITER_LZB_EN defined:
  - Leading-zero blanking is on.
  - Digits more significant than the first nonzero digit become CHAR_BLANK.
  - The least significant digit is always printed, so value 0 shows as blanks followed by '0'.
- Not defined: digits are zero-padded.
- Timing is identical in both builds.

## Structure
- The ui package gains the CHAR_BLANK, CHAR_ZERO and CHAR_SUFFIX constants and the field base addresses.
- The state enum stays local.
- One sub-module, bcd_shift_core, holds the double-dabble datapath: load, step, bcd digit array, step count.
- The FSM and the emit/blanking logic live in bcd_field_writer.

## Test plan
All tests use WIDTH=8, DIGITS=3, FIELD_BASE=10'h001 and i_attr=8'h02 unless noted.
- value 205 -> writes (001,3202) (002,3002) (003,3502) (004,BB02) on cycles 9-12. o_done on cycle 13.
- value 7:
  - with LZB_EN -> F602, F602, 3702, BB02.
  - without LZB_EN -> 3002, 3002, 3702, BB02.
- value 8'hFF (untracked) -> F602, F602, F602, BB02.
- Start 205, then i_start with value 99 at cycles 3 and 12 -> only the 205 sequence occurs. o_busy is never dropped early.
- Reset asserted at cycle 10 -> o_we=0 immediately, no o_done. A start after release produces the full correct sequence.
- FIELD_BASE=10'h3FE, value 205 -> addresses 3FE, 3FF, 000, 001.

Source files
------------

// File: rtl/ui_pkg.sv
// UI state RAM constants shared by the numeric field writers: character codes,
// field base addresses and the minimum decimal digit count for a binary width.
package ui;

  localparam logic [7:0] CHAR_BLANK  = 8'hF6;
  localparam logic [7:0] CHAR_ZERO   = 8'h30;
  localparam logic [7:0] CHAR_SUFFIX = 8'hBB;

  localparam logic [9:0] FIELD_BASE_SCORE = 10'h001;
  localparam logic [9:0] FIELD_BASE_TIMER = 10'h020;
  localparam logic [9:0] FIELD_BASE_LEVEL = 10'h040;

  // ceil(log10(2) * width); width*log10(2) is never an exact integer for width > 0
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// Sequential double-dabble datapath: one add-3/shift step per cycle, WIDTH steps
// per conversion, with a terminal-count down-counter flagging the final step.
module bcd_shift_core #(
  parameter int WIDTH  = 28,
  parameter int DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [WIDTH-1:0]      value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   bcd_next,
  output logic                  last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    bin;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
  end

  // Combinational view of the next step lets the writer emit on the very next cycle
  assign bcd_next = {adj[4*DIGITS-2:0], bin[WIDTH-1]};
  assign last     = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      bin <= value;
      bcd <= '0;
      cnt <= CW'(WIDTH);
    end else if (step && (cnt != '0)) begin
      bin <= {bin[WIDTH-2:0], 1'b0};
      bcd <= bcd_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/bcd_field_writer.sv
// Converts a binary value to decimal and writes DIGITS digit cells plus a suffix
// cell into the UI state RAM. Define BCD_FIELD_WRITER_LZB_EN for leading-zero blanking.
//
// state     | meaning
// S_IDLE    | waiting for i_start; accepting loads the shift core
// S_CONVERT | WIDTH double-dabble steps, no writes
// S_EMIT    | DIGITS digit writes (MS first) then the suffix write
// S_DONE    | one-cycle o_done, i_start ignored
module bcd_field_writer
  import ui::*;
#(
  parameter int         WIDTH      = 28,
  parameter int         DIGITS     = ui::min_digits(WIDTH),
  parameter logic [9:0] FIELD_BASE = 10'h000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_value,
  input  logic [7:0]       i_attr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_we,
  output logic [9:0]       o_waddr,
  output logic [15:0]      o_wdata
);

  localparam int KW = $clog2(DIGITS + 1);

  if (DIGITS < ui::min_digits(WIDTH)) begin : g_digits_check
    $error("bcd_field_writer: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_DONE} state_t;

  state_t              state, state_nx;
  logic [KW-1:0]       idx, idx_nx;
  logic                load, step, last;
  logic                untracked;
  logic [7:0]          attr;
  logic [4*DIGITS-1:0] bcd, bcd_next, src;
  logic [DIGITS-1:0]   blank_mask;
  logic [3:0]          digit_sel;
  logic                blank_sel;
  logic [7:0]          char_nx;
  logic [9:0]          waddr_nx;

  bcd_shift_core #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_core (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (load),
    .step     (step),
    .value    (i_value),
    .bcd      (bcd),
    .bcd_next (bcd_next),
    .last     (last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nx = S_CONVERT;
          load     = 1'b1;
        end
      end
      S_CONVERT: begin
        step = 1'b1;
        if (last) begin
          state_nx = S_EMIT;
          idx_nx   = '0;
        end
      end
      S_EMIT: begin
        if (idx == KW'(DIGITS)) state_nx = S_DONE;
        else                    idx_nx   = idx + KW'(1);
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // First cell is registered on the last conversion edge, so read the core's step result
  assign src = (state == S_CONVERT) ? bcd_next : bcd;

  always_comb begin
    logic lz;
    lz         = 1'b1;
    blank_mask = '0;
`ifdef BCD_FIELD_WRITER_LZB_EN
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz            = lz & (src[i*4 +: 4] == 4'd0);
      blank_mask[i] = lz && (i != 0);
    end
`endif
  end

  always_comb begin
    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nx == KW'(DIGITS - 1 - i)) begin
        digit_sel = src[i*4 +: 4];
        blank_sel = blank_mask[i];
      end
    end
    if (idx_nx == KW'(DIGITS))        char_nx = CHAR_SUFFIX;
    else if (untracked || blank_sel)  char_nx = CHAR_BLANK;
    else                              char_nx = CHAR_ZERO + {4'd0, digit_sel};
    waddr_nx = FIELD_BASE + 10'(idx_nx);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      untracked <= 1'b0;
      attr      <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_we      <= 1'b0;
      o_waddr   <= '0;
      o_wdata   <= '0;
    end else begin
      if (load) begin
        untracked <= &i_value;
        attr      <= i_attr;
      end
      o_busy <= (state_nx == S_CONVERT) || (state_nx == S_EMIT);
      o_done <= (state_nx == S_DONE);
      o_we   <= (state_nx == S_EMIT);
      if (state_nx == S_EMIT) begin
        o_waddr <= waddr_nx;
        o_wdata <= {char_nx, attr};
      end
    end
  end

endmodule
